// File: rtl/hamming_weight_enum.sv
// Enumerates every BIT_STRING_LEN-bit string of a requested Hamming weight, in increasing order.
// Latency: first string one cycle after an accepted start, then one string per accepted handshake.
// Backpressure: valid/ready on bit_string; a stall holds bit_string and last stable.
// Optional build macro HW_ENUM_SELFCHECK_EN adds a popcount self-check and a sticky chk_fail output.
module hamming_weight_enum #(
    parameter int BIT_STRING_LEN     = 8,
    parameter int HAMMING_WEIGHT_LEN = 4,
    parameter int COUNT_LEN          = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [HAMMING_WEIGHT_LEN-1:0] target_weight,
    output logic [BIT_STRING_LEN-1:0]     bit_string,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          last,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
`ifdef HW_ENUM_SELFCHECK_EN
    output logic                          chk_fail,
`endif
    output logic [COUNT_LEN-1:0]          seq_count
);

    localparam int N   = BIT_STRING_LEN;
    localparam int TZW = $clog2(N + 1) + 1;
    localparam logic [HAMMING_WEIGHT_LEN-1:0] MAX_W    = HAMMING_WEIGHT_LEN'(N);
    localparam logic [N-1:0]                  ALL_ONES = '1;
    localparam logic [N:0]                    EXT_ONE  = (N + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [HAMMING_WEIGHT_LEN-1:0] w_lat;
    logic                          err_q;
    logic                          accept;
    logic                          w_bad;
    logic                          hs;
    logic [N-1:0]                  last_pat;
    logic [N-1:0]                  init_pat;
    logic [N:0]                    x_ext;
    logic [N:0]                    low_bit;
    logic [N:0]                    ripple;
    logic [N:0]                    ones;
    logic [TZW-1:0]                tz;
    logic [N-1:0]                  succ;

    assign accept   = (state == IDLE) && start;
    assign w_bad    = target_weight > MAX_W;
    assign hs       = out_valid && out_ready;
    // Final string of a class has all w ones packed at the MSB end.
    assign last_pat = ~(ALL_ONES >> w_lat);
    // Extra bit keeps (1<<w)-1 exact for w == BIT_STRING_LEN.
    assign init_pat = N'((EXT_ONE << target_weight) - EXT_ONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = w_bad ? FIN : RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                last      = (bit_string == last_pat);
                if (out_ready && last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gosper successor at N+1 bits: add the lowest set bit, then refill the displaced
    // ones at the bottom; the division by the lowest bit becomes a shift by its index.
    always_comb begin
        x_ext   = {1'b0, bit_string};
        low_bit = x_ext & (~x_ext + EXT_ONE);
        ripple  = x_ext + low_bit;
        ones    = (ripple ^ x_ext) >> 2;
        tz      = '0;
        for (int i = N; i >= 0; i--) begin
            if (x_ext[i]) begin
                tz = TZW'(i);
            end
        end
        succ = N'((ones >> tz) | ripple);
    end

    // Datapath: latch weight on start, advance string and count on each handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_string <= '0;
            w_lat      <= '0;
            err_q      <= 1'b0;
            seq_count  <= '0;
        end else if (accept) begin
            w_lat     <= target_weight;
            err_q     <= w_bad;
            seq_count <= '0;
            if (!w_bad) begin
                bit_string <= init_pat;
            end
        end else if (hs) begin
            seq_count <= seq_count + COUNT_LEN'(1);
            if (!last) begin
                bit_string <= succ;
            end
        end
    end

`ifdef HW_ENUM_SELFCHECK_EN
    logic [HAMMING_WEIGHT_LEN-1:0] tree [0:N-1];
    logic [HAMMING_WEIGHT_LEN-1:0] popcnt;

    // Pairwise adder tree popcount of the presented string.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            tree[i] = HAMMING_WEIGHT_LEN'(bit_string[i]);
        end
        for (int s = 1; s < N; s = s * 2) begin
            for (int i = 0; i + s < N; i = i + 2 * s) begin
                tree[i] = tree[i] + tree[i + s];
            end
        end
        popcnt = tree[0];
    end

    // Sticky flag: any presented string whose weight differs from the latched target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_fail <= 1'b0;
        end else if (out_valid && (popcnt != w_lat)) begin
            chk_fail <= 1'b1;
        end
    end
`endif

endmodule
